pc_fetch_unit: RTL and testbench

Fetch-stage program-counter block that sits directly downstream of the hazard unit and consumes its branch decision. It holds the architectural fetch PC and advances it sequentially, redirects it on a taken branch, and services call/return through a small internal return-address stack (RAS) driven by push/pop requests from execute. It produces the PC presented to instruction memory and the F/D pipeline register.

---
 rtl/pc_fetch_unit_pkg.sv | 17 +
 rtl/pc_fetch_unit_ras_stack.sv | 98 +++++++++
 rtl/pc_fetch_unit.sv | 79 +++++++
 tb/tb_pc_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: default PC geometry and the next-PC source encoding
// also consumed by the hazard and debug logic.
package pc_fetch_unit_pkg;

  localparam int unsigned DefaultPcWidth = 32;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [2:0] {
    NpcRst,
    NpcBranch,
    NpcRas,
    NpcFallback,
    NpcHold,
    NpcSeq
  } npc_src_e;

endpackage

// File: rtl/pc_fetch_unit_ras_stack.sv
// Circular return-address stack with saturating count, sticky overflow/underflow flags
// and in-place top replacement when push and pop coincide.
module pc_fetch_unit_ras_stack
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = DefaultPcWidth,
  parameter int unsigned RAS_DEPTH = 8,
  localparam int unsigned PtrW     = $clog2(RAS_DEPTH),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [PC_WIDTH-1:0] i_push_data,
  output logic [PC_WIDTH-1:0] o_top,
  output logic [CntW-1:0]     o_count,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_overflow,
  output logic                o_underflow
);

  logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PtrW-1:0]     r_ptr;
  logic [CntW-1:0]     r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic [PtrW-1:0]     w_ptr_d;
  logic [CntW-1:0]     w_count_d;
  logic                w_overflow_d;
  logic                w_underflow_d;
  logic                w_we;
  logic [PtrW-1:0]     w_waddr;
  logic                w_empty;
  logic                w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(RAS_DEPTH));

  always_comb begin
    w_ptr_d       = r_ptr;
    w_count_d     = r_count;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;
    w_we          = 1'b0;
    w_waddr       = r_ptr;
    if (i_push && i_pop) begin
      // Replace the top in place; an empty stack gains its first entry.
      w_we = 1'b1;
      if (w_empty) begin
        w_count_d     = CntW'(1);
        w_underflow_d = 1'b1;
      end
    end else if (i_push) begin
      w_we    = 1'b1;
      w_ptr_d = r_ptr + PtrW'(1);
      w_waddr = w_ptr_d;
      if (w_full) w_overflow_d = 1'b1;
      else        w_count_d    = r_count + CntW'(1);
    end else if (i_pop) begin
      if (w_empty) begin
        w_underflow_d = 1'b1;
      end else begin
        w_ptr_d   = r_ptr - PtrW'(1);
        w_count_d = r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_d;
      r_count     <= w_count_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // Contents need no reset; a request in a reset cycle is discarded.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_we) r_mem[w_waddr] <= i_push_data;
  end

  assign o_top       = r_mem[r_ptr];
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and next-PC selection: reset, branch redirect, RAS return,
// underflow fallback, stall hold or sequential increment.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = DefaultPcWidth,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(DefaultResetPc),
  parameter int unsigned          RAS_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_stall,
  input  logic                          i_branch_decision,
  input  logic [PC_WIDTH-1:0]           i_branch_target,
  input  logic                          i_push_pc,
  input  logic [PC_WIDTH-1:0]           i_return_addr,
  input  logic                          i_pop_pc,
  output logic [PC_WIDTH-1:0]           o_pc,
  output logic [PC_WIDTH-1:0]           o_pc_plus1,
  output logic [$clog2(RAS_DEPTH):0]    o_ras_count,
  output logic                          o_ras_empty,
  output logic                          o_ras_full,
  output logic                          o_ras_overflow,
  output logic                          o_ras_underflow
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_d;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic                w_ras_empty;
  npc_src_e            w_npc_sel;

  pc_fetch_unit_ras_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_push_pc),
    .i_pop       (i_pop_pc),
    .i_push_data (i_return_addr),
    .o_top       (w_ras_top),
    .o_count     (o_ras_count),
    .o_empty     (w_ras_empty),
    .o_full      (o_ras_full),
    .o_overflow  (o_ras_overflow),
    .o_underflow (o_ras_underflow)
  );

  always_comb begin
    if (!i_rst_n)                        w_npc_sel = NpcRst;
    else if (i_branch_decision)          w_npc_sel = NpcBranch;
    else if (i_pop_pc && !w_ras_empty)   w_npc_sel = NpcRas;
    else if (i_pop_pc)                   w_npc_sel = NpcFallback;
    else if (i_stall)                    w_npc_sel = NpcHold;
    else                                 w_npc_sel = NpcSeq;
  end

  always_comb begin
    w_pc_d = r_pc;
    unique case (w_npc_sel)
      NpcRst:                  w_pc_d = RESET_PC;
      NpcBranch, NpcFallback:  w_pc_d = i_branch_target;
      NpcRas:                  w_pc_d = w_ras_top;
      NpcHold:                 w_pc_d = r_pc;
      NpcSeq:                  w_pc_d = r_pc + PC_WIDTH'(1);
      default:                 w_pc_d = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_pc <= w_pc_d;
  end

  assign o_pc        = r_pc;
  assign o_pc_plus1  = r_pc + PC_WIDTH'(1);
  assign o_ras_empty = w_ras_empty;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch PC and return stack.
module tb_pc_fetch_unit;

  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam logic [PW-1:0] RPC = '0;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          branch;
  logic [PW-1:0] target;
  logic          push;
  logic [PW-1:0] ret;
  logic          pop;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_plus1;
  logic [CW-1:0] ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_ovf;
  logic          ras_unf;

  int checks = 0;
  int errors = 0;

  // Reference model: the stack is a queue, newest at the back.
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;

  pc_fetch_unit #(
    .PC_WIDTH  (PW),
    .RESET_PC  (RPC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_stall           (stall),
    .i_branch_decision (branch),
    .i_branch_target   (target),
    .i_push_pc         (push),
    .i_return_addr     (ret),
    .i_pop_pc          (pop),
    .o_pc              (pc),
    .o_pc_plus1        (pc_plus1),
    .o_ras_count       (ras_count),
    .o_ras_empty       (ras_empty),
    .o_ras_full        (ras_full),
    .o_ras_overflow    (ras_ovf),
    .o_ras_underflow   (ras_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic model_step();
    logic [PW-1:0] npc;
    if (!rst_n) begin
      m_pc  = RPC;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (branch)     npc = target;
      else if (pop)   npc = (m_q.size() > 0) ? m_q[$] : target;
      else if (stall) npc = m_pc;
      else            npc = m_pc + 1;
      if (push && pop) begin
        if (m_q.size() > 0) m_q[$] = ret;
        else begin
          m_q.push_back(ret);
          m_unf = 1'b1;
        end
      end else if (push) begin
        m_q.push_back(ret);
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
      end else if (pop) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_unf = 1'b1;
      end
      m_pc = npc;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; branch = 1'b0; push = 1'b0; pop = 1'b0;
    target = '0; ret = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; push = 1'b1; pop = 1'b1; branch = 1'b1; target = 32'h1234; ret = 32'h99;
    tick();
    tick();
    checks++; if (pc !== RPC) begin errors++;
      $display("FAIL reset_pc: got %h exp %h", pc, RPC); end
    checks++; if (ras_count !== 4'd0) begin errors++;
      $display("FAIL reset_count: got %0d exp 0", ras_count); end
    checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin errors++;
      $display("FAIL reset_flags: got e%b f%b o%b u%b exp e1 f0 o0 u0",
               ras_empty, ras_full, ras_ovf, ras_unf); end
    idle();
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== PW'(i)) begin errors++;
        $display("FAIL seq_pc[%0d]: got %h exp %h", i, pc, PW'(i)); end
      checks++; if (pc_plus1 !== PW'(i + 1)) begin errors++;
        $display("FAIL seq_plus1[%0d]: got %h exp %h", i, pc_plus1, PW'(i + 1)); end
      checks++; if (ras_empty !== 1'b1) begin errors++;
        $display("FAIL seq_empty[%0d]: got %b exp 1", i, ras_empty); end
    end
  endtask

  task automatic test_stall_branch();
    tick();
    checks++; if (pc !== 32'd5) begin errors++;
      $display("FAIL stall_pre: got %h exp 5", pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'd5) begin errors++;
        $display("FAIL stall_hold[%0d]: got %h exp 5", i, pc); end
    end
    branch = 1'b1; target = 32'h40;
    tick();
    checks++; if (pc !== 32'h40) begin errors++;
      $display("FAIL stall_branch: got %h exp 40", pc); end
    idle();
  endtask

  task automatic test_ras_lifo();
    logic [PW-1:0] exp_pc [3];
    exp_pc[0] = 32'h30; exp_pc[1] = 32'h20; exp_pc[2] = 32'h10;
    push = 1'b1;
    ret = 32'h10; tick();
    ret = 32'h20; tick();
    ret = 32'h30; tick();
    checks++; if (ras_count !== 4'd3) begin errors++;
      $display("FAIL lifo_count_full: got %0d exp 3", ras_count); end
    push = 1'b0; pop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc !== exp_pc[k]) begin errors++;
        $display("FAIL lifo_pop_pc[%0d]: got %h exp %h", k, pc, exp_pc[k]); end
      checks++; if (ras_count !== CW'(2 - k)) begin errors++;
        $display("FAIL lifo_pop_count[%0d]: got %0d exp %0d", k, ras_count, 2 - k); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++;
      $display("FAIL lifo_empty: got %b exp 1", ras_empty); end
    idle();
  endtask

  task automatic test_overflow_underflow();
    logic [PW-1:0] exp;
    push = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      ret = PW'(i);
      tick();
    end
    checks++; if (ras_count !== 4'd8 || ras_full !== 1'b1 || ras_ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_state: got cnt %0d full %b ovf %b exp 8 1 1",
               ras_count, ras_full, ras_ovf); end
    push = 1'b0; pop = 1'b1; target = 32'hFF;
    for (int k = 0; k < 9; k++) begin
      exp = (k < 8) ? PW'(9 - k) : 32'hFF;
      tick();
      checks++; if (pc !== exp) begin errors++;
        $display("FAIL ovf_pop_pc[%0d]: got %h exp %h", k, pc, exp); end
    end
    checks++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b1 || ras_count !== 4'd0) begin errors++;
      $display("FAIL unf_state: got unf %b ovf %b cnt %0d exp 1 1 0",
               ras_unf, ras_ovf, ras_count); end
    idle();
  endtask

  task automatic test_push_pop_same();
    push = 1'b1;
    ret = 32'h10; tick();
    ret = 32'h20; tick();
    pop = 1'b1; ret = 32'h50;
    tick();
    checks++; if (pc !== 32'h20) begin errors++;
      $display("FAIL pushpop_pc: got %h exp 20", pc); end
    checks++; if (ras_count !== 4'd2) begin errors++;
      $display("FAIL pushpop_count: got %0d exp 2", ras_count); end
    push = 1'b0;
    tick();
    checks++; if (pc !== 32'h50) begin errors++;
      $display("FAIL pushpop_next: got %h exp 50", pc); end
    idle();
  endtask

  task automatic test_wrap_reset();
    branch = 1'b1; target = '1;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFF || pc_plus1 !== 32'h0) begin errors++;
      $display("FAIL wrap_max: got pc %h plus1 %h exp ffffffff 0", pc, pc_plus1); end
    branch = 1'b0;
    tick();
    checks++; if (pc !== 32'h0) begin errors++;
      $display("FAIL wrap_zero: got %h exp 0", pc); end
    push = 1'b1; ret = 32'h77;
    tick();
    push = 1'b0; pop = 1'b1; rst_n = 1'b0;
    tick();
    checks++; if (pc !== RPC || ras_count !== 4'd0) begin errors++;
      $display("FAIL midpop_reset: got pc %h cnt %0d exp %h 0", pc, ras_count, RPC); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0 || ras_empty !== 1'b1) begin errors++;
      $display("FAIL midpop_flags: got o%b u%b e%b exp o0 u0 e1", ras_ovf, ras_unf, ras_empty); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      stall  = $urandom_range(0, 1) == 1;
      branch = $urandom_range(0, 3) == 0;
      push   = $urandom_range(0, 2) != 0;
      pop    = $urandom_range(0, 2) == 0;
      target = $urandom;
      ret    = $urandom;
      tick();
      checks++; if (pc !== m_pc) begin errors++;
        $display("FAIL rnd_pc[%0d]: got %h exp %h", n, pc, m_pc); end
      checks++; if (pc_plus1 !== m_pc + 1) begin errors++;
        $display("FAIL rnd_plus1[%0d]: got %h exp %h", n, pc_plus1, m_pc + 1); end
      checks++; if (ras_count !== CW'(m_q.size())) begin errors++;
        $display("FAIL rnd_count[%0d]: got %0d exp %0d", n, ras_count, m_q.size()); end
      checks++; if (ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH))
        begin errors++;
        $display("FAIL rnd_ef[%0d]: got e%b f%b exp size %0d", n, ras_empty, ras_full,
                 m_q.size()); end
      checks++; if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin errors++;
        $display("FAIL rnd_sticky[%0d]: got o%b u%b exp o%b u%b", n, ras_ovf, ras_unf,
                 m_ovf, m_unf); end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall_branch();
    test_ras_lifo();
    test_overflow_underflow();
    test_push_pop_same();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
